origin_tracker: RTL and testbench

ORIGIN_TRACKER -- requirements
Module: origin_tracker

---
 rtl/origin_tracker_pkg.sv | 28 ++
 rtl/origin_tracker_if.sv | 24 ++
 rtl/origin_fifo.sv | 71 +++++++
 rtl/origin_tracker.sv | 77 +++++++
 tb/tb_origin_tracker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/origin_tracker_pkg.sv
// Shared types for the origin tracker: origin tag, memory network messages
// and the default tracking depth.
package origin_tracker_pkg;

    localparam int ORIGIN_W      = 2;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [ORIGIN_W-1:0] origin_t;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        origin_t     origin;
        mem_op_e     op;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_net_req_t;

    typedef struct packed {
        origin_t     origin;
        mem_op_e     op;
        logic [31:0] data;
    } mem_net_resp_t;

endpackage

// File: rtl/origin_tracker_if.sv
// Memory network request and response channels.
// Handshake: a beat transfers on a rising edge where val and rdy are both 1;
// the producer owns val/msg, the consumer owns rdy.
interface mem_net_req_if;
    import origin_tracker_pkg::*;

    logic         val;
    logic         rdy;
    mem_net_req_t msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

interface mem_net_resp_if;
    import origin_tracker_pkg::*;

    logic          val;
    logic          rdy;
    mem_net_resp_t msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/origin_fifo.sv
// Circular tag FIFO with registered occupancy; full/empty come only from
// registered state so a same-cycle pop never frees a slot for a push.
module origin_fifo #(
    parameter int p_width = 2,
    parameter int p_depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [p_width-1:0]           din,
    input  logic                         pop,
    output logic [p_width-1:0]           dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = $clog2(p_depth + 1);

    logic [p_width-1:0] mem_q [p_depth];
    logic [p_width-1:0] mem_d [p_depth];
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == CNT_W'(p_depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state: write at wptr, read at rptr; pointers wrap by power-of-two overflow.
    always_comb begin
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every stored tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < p_depth; i++) mem_q[i] <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/origin_tracker.sv
// Records the origin of each request sent to memory and stamps it onto the
// matching in-order response. Only gating and error detection live here;
// tag storage is in origin_fifo.
module origin_tracker
    import origin_tracker_pkg::*;
#(
    parameter int p_num_origin = 3,
    parameter int p_depth      = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    mem_net_req_if.slave                 req_in,
    mem_net_req_if.master                mem_req,
    mem_net_resp_if.slave                mem_resp,
    mem_net_resp_if.master               resp_out,
    output logic [$clog2(p_depth+1)-1:0] outstanding,
    output logic                         err
);

    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    origin_t head;
    logic    err_q, err_d;
    logic    bad_origin;

    origin_fifo #(
        .p_width (ORIGIN_W),
        .p_depth (p_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req_in.msg.origin),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    // Request path: forward straight through, stalled only while the tag store is full.
    always_comb begin
        mem_req.msg = req_in.msg;
        mem_req.val = req_in.val & ~full & ~rst;
        req_in.rdy  = mem_req.rdy & ~full;
        push        = req_in.val & req_in.rdy;
    end

    // Response path: a response with no tracked request is held, never accepted.
    always_comb begin
        resp_out.msg        = mem_resp.msg;
        resp_out.msg.origin = head;
        resp_out.val        = mem_resp.val & ~empty;
        mem_resp.rdy        = resp_out.rdy & ~empty;
        pop                 = resp_out.val & resp_out.rdy;
    end

    assign bad_origin = ({30'd0, req_in.msg.origin} >= p_num_origin);

    // Sticky error: unexpected response or out-of-range origin on an accepted request.
    always_comb begin
        err_d = err_q;
        if (mem_resp.val & empty) err_d = 1'b1;
        if (push & bad_origin)    err_d = 1'b1;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;

endmodule

// File: tb/tb_origin_tracker.sv
// Directed and random stimulus against a queue model of outstanding origins.
module tb_origin_tracker;
    import origin_tracker_pkg::*;

    localparam int DEPTH      = 8;
    localparam int NUM_ORIGIN = 3;

    logic       clk;
    logic       rst;
    logic [3:0] outstanding;
    logic       err;

    mem_net_req_if  req_in_if ();
    mem_net_req_if  mem_req_if ();
    mem_net_resp_if mem_resp_if ();
    mem_net_resp_if resp_out_if ();

    origin_tracker #(
        .p_num_origin (NUM_ORIGIN),
        .p_depth      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in_if),
        .mem_req     (mem_req_if),
        .mem_resp    (mem_resp_if),
        .resp_out    (resp_out_if),
        .outstanding (outstanding),
        .err         (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    logic [1:0]  exp_q[$];
    logic        err_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver
    task automatic set(input logic rv, input logic [1:0] org, input logic mrdy,
                       input logic sv, input logic srdy);
        req_in_if.val          = rv;
        req_in_if.msg.origin   = org;
        req_in_if.msg.op       = mem_op_e'($urandom_range(0, 1));
        req_in_if.msg.addr     = 16'($urandom);
        req_in_if.msg.data     = $urandom;
        mem_req_if.rdy         = mrdy;
        mem_resp_if.val        = sv;
        mem_resp_if.msg.origin = 2'($urandom);
        mem_resp_if.msg.op     = mem_op_e'($urandom_range(0, 1));
        mem_resp_if.msg.data   = $urandom;
        resp_out_if.rdy        = srdy;
    endtask

    // one clock of the design checked against the model
    task automatic cycle();
        bit full_m, empty_m, push_m, pop_m;
        full_m  = (exp_q.size() == DEPTH);
        empty_m = (exp_q.size() == 0);
        #1;
        check("req_rdy",  64'(req_in_if.rdy),  64'(mem_req_if.rdy & !full_m));
        check("mem_val",  64'(mem_req_if.val), 64'(req_in_if.val & !full_m));
        check("mem_msg",  64'(mem_req_if.msg), 64'(req_in_if.msg));
        check("resp_val", 64'(resp_out_if.val), 64'(mem_resp_if.val & !empty_m));
        check("resp_rdy", 64'(mem_resp_if.rdy), 64'(resp_out_if.rdy & !empty_m));
        if (!empty_m && mem_resp_if.val) begin
            check("resp_origin", 64'(resp_out_if.msg.origin), 64'(exp_q[0]));
            check("resp_data",   64'(resp_out_if.msg.data),   64'(mem_resp_if.msg.data));
        end
        push_m = req_in_if.val & mem_req_if.rdy & !full_m;
        pop_m  = mem_resp_if.val & resp_out_if.rdy & !empty_m;
        if (mem_resp_if.val && empty_m) err_m = 1'b1;
        if (push_m && int'(req_in_if.msg.origin) >= NUM_ORIGIN) err_m = 1'b1;
        @(posedge clk);
        #1;
        if (pop_m)  void'(exp_q.pop_front());
        if (push_m) exp_q.push_back(req_in_if.msg.origin);
        check("outstanding", 64'(outstanding), 64'(exp_q.size()));
        check("err",         64'(err),         64'(err_m));
    endtask

    // asynchronous reset pulse landing mid-cycle
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_outstanding", 64'(outstanding),     64'(0));
        check("rst_err",         64'(err),             64'(0));
        check("rst_resp_val",    64'(resp_out_if.val), 64'(0));
        check("rst_resp_rdy",    64'(mem_resp_if.rdy), 64'(0));
        check("rst_mem_val",     64'(mem_req_if.val),  64'(0));
        exp_q.delete();
        err_m = 1'b0;
        set(0, 0, 1, 0, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq29 [8];
        total = 0;
        bad   = 0;
        err_m = 1'b0;
        rst   = 1'b1;
        seq29 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        // reset state with both valids asserted
        set(1, 1, 1, 1, 1);
        #3;
        check("reset_outstanding", 64'(outstanding),     64'(0));
        check("reset_err",         64'(err),             64'(0));
        check("reset_resp_val",    64'(resp_out_if.val), 64'(0));
        check("reset_resp_rdy",    64'(mem_resp_if.rdy), 64'(0));
        check("reset_mem_val",     64'(mem_req_if.val),  64'(0));
        set(0, 0, 1, 0, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // single request origin 2, response next cycle
        set(1, 2, 1, 0, 1);
        cycle();
        check("single_out1", 64'(outstanding), 64'(1));
        set(0, 0, 1, 1, 1);
        cycle();
        check("single_out0", 64'(outstanding), 64'(0));

        // fill to depth with responses held off, ninth request stalls
        for (int i = 0; i < 8; i++) begin
            set(1, seq29[i], 1, 0, 1);
            cycle();
        end
        check("fill_out8", 64'(outstanding), 64'(8));
        set(1, 2, 1, 0, 1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            set(0, 0, 1, 1, 1);
            cycle();
        end
        check("drain_out0", 64'(outstanding), 64'(0));

        // full with pending request and same-cycle pop: accepted one cycle later
        for (int i = 0; i < 8; i++) begin
            set(1, 2'(i % 3), 1, 0, 1);
            cycle();
        end
        set(1, 1, 1, 1, 1);
        cycle();
        check("fullpop_out7", 64'(outstanding), 64'(7));
        set(1, 1, 1, 0, 1);
        cycle();
        check("fullpop_out8", 64'(outstanding), 64'(8));

        // drain to half, then steady push+pop so both pointers wrap
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 1, 1, 1);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            set(1, 2'($urandom_range(0, 2)), 1, 1, 1);
            cycle();
            check("steady_out4", 64'(outstanding), 64'(4));
        end
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 1, 1, 1);
            cycle();
        end

        // unexpected response while empty: held, err sets and sticks
        set(0, 0, 1, 1, 1);
        cycle();
        check("unexp_err", 64'(err), 64'(1));
        set(0, 0, 1, 0, 1);
        cycle();
        check("unexp_err_sticky", 64'(err), 64'(1));

        // out-of-range origin after a clean reset
        async_reset();
        set(1, 3, 1, 0, 1);
        cycle();
        check("origin3_err", 64'(err), 64'(1));
        set(0, 0, 1, 1, 1);
        cycle();

        // asynchronous reset with five outstanding
        async_reset();
        for (int i = 0; i < 5; i++) begin
            set(1, 2'(i % 3), 1, 0, 1);
            cycle();
        end
        check("pre_rst_out5", 64'(outstanding), 64'(5));
        mem_resp_if.val = 1'b1;
        async_reset();
        set(1, 1, 1, 0, 1);
        cycle();
        set(0, 0, 1, 1, 1);
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set(1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
            cycle();
        end

        // bounded drain
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            set(0, 0, 1, 1, 1);
            cycle();
        end
        check("final_empty", 64'(outstanding), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
